// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared types and limits for the down_timer block.
//   state_t   - FSM state encoding (IDLE, RUN)
//   MIN_WIDTH - smallest legal counter width
//   MAX_WIDTH - largest legal counter width
package down_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 16;

endpackage

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with valid/ready load handshake,
// one-cycle expiry pulse and sticky done flag.
//
// Optional feature macro: DOWN_TIMER_AUTO_RELOAD_EN
//   defined   - periodic mode: the last accepted load value is reloaded on
//               every expiry, loads are accepted while running.
//   undefined - one-shot mode, no reload register.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   load_valid in   producer offers load_value
//   load_value in   start value N (WIDTH bits, unsigned)
//   load_ready out  timer can accept a load this cycle
//   enable     in   count enable while running
//   abort      in   cancel the running timer
//   done_clr   in   clear sticky done
//   count      out  current count value
//   busy       out  high while running
//   expired    out  one-cycle pulse on terminal count
//   done       out  sticky expiry flag
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             enable,
    input  logic             abort,
    input  logic             done_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             done
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("down_timer: WIDTH out of legal range");
    end

    state_t state;
    logic   load_fire;
    logic   expire_now;

    assign load_fire  = load_valid && load_ready;
    // Terminal count reached on an enabled cycle; abort suppresses it.
    assign expire_now = (state == RUN) && enable && !abort && (count == '0);
    assign busy       = (state == RUN);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_next;

    assign load_ready  = 1'b1;
    // A load landing on the expiry edge is used immediately for the reload.
    assign reload_next = load_fire ? load_value : reload_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_q <= '0;
        end else if (load_fire) begin
            reload_q <= load_value;
        end
    end
`else
    assign load_ready = (state == IDLE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            expired <= expire_now;

            // Set wins over a coincident clear.
            if (expire_now) begin
                done <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (load_fire) begin
                        count <= load_value;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (enable) begin
                        if (count != '0) begin
                            count <= count - WIDTH'(1);
                        end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                            count <= reload_next;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: randomized + directed self-checking bench for down_timer.
// The reference model tracks "enabled edges remaining until expiry" rather
// than the count register itself.
module tb_down_timer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;
    logic             enable;
    logic             abort;
    logic             done_clr;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;
    logic             done;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .enable     (enable),
        .abort      (abort),
        .done_clr   (done_clr),
        .count      (count),
        .busy       (busy),
        .expired    (expired),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state.
    bit m_run;
    int m_left;      // enabled edges remaining until expiry while running
    int m_idle_cnt;  // count shown while idle
    bit m_done;
    bit m_exp;
    int m_rel;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    function automatic bit m_ready();
        return RELOAD || !m_run;
    endfunction

    function automatic int m_count();
        return m_run ? m_left - 1 : m_idle_cnt;
    endfunction

    task automatic model_reset();
        m_run = 0; m_left = 0; m_idle_cnt = 0; m_done = 0; m_exp = 0; m_rel = 0;
    endtask

    task automatic model_step(input bit lv, input int lval, input bit en, input bit ab, input bit dc);
        bit fire;
        bit hit;
        fire = lv && m_ready();
        hit  = 0;
        if (fire) m_rel = lval;
        if (!m_run) begin
            if (fire) begin
                m_run  = 1;
                m_left = lval + 1;
            end
        end else if (ab) begin
            m_run      = 0;
            m_idle_cnt = 0;
        end else if (en) begin
            m_left--;
            if (m_left == 0) begin
                hit = 1;
                if (RELOAD) m_left = m_rel + 1;
                else begin
                    m_run      = 0;
                    m_idle_cnt = 0;
                end
            end
        end
        m_exp = hit;
        if (hit) m_done = 1;
        else if (dc) m_done = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},      32'(count),      32'(m_count()));
        check({tag, ".busy"},       32'(busy),       32'(m_run));
        check({tag, ".expired"},    32'(expired),    32'(m_exp));
        check({tag, ".done"},       32'(done),       32'(m_done));
        check({tag, ".load_ready"}, 32'(load_ready), 32'(m_ready()));
    endtask

    // Drive one cycle's inputs, take one edge, update model, compare #1 later.
    task automatic cycle(input string tag, input bit lv, input int lval,
                         input bit en, input bit ab, input bit dc);
        load_valid = lv;
        load_value = WIDTH'(lval);
        enable     = en;
        abort      = ab;
        done_clr   = dc;
        @(posedge clk);
        model_step(lv, lval, en, ab, dc);
        #1;
        check_all(tag);
    endtask

    initial begin
        int edges;
        int pulses;
        bit pend;
        int pval;
        int q[$];

        reset = 1'b1; load_valid = 0; load_value = '0; enable = 0; abort = 0; done_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Async reset mid-run with count 5.
        cycle("ld5", 1, 5, 0, 0, 0);
        check("ld5.count_const", 32'(count), 32'd5);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.ready_const", 32'(load_ready), 32'd1);
        #1 reset = 1'b0;

        // Load 3, enable high: expiry on the 4th enabled edge.
        cycle("ld3", 1, 3, 0, 0, 0);
        check("ld3.count_const", 32'(count), 32'd3);
        edges = 0; pulses = 0;
        while (edges < 12 && pulses == 0) begin
            cycle("run3", 0, 0, 1, 0, 0);
            edges++;
            if (expired) pulses++;
        end
        check("run3.edges_to_expiry", 32'(edges), 32'd4);
        check("run3.done_const", 32'(done), 32'd1);
`ifndef DOWN_TIMER_AUTO_RELOAD_EN
        check("run3.busy_const", 32'(busy), 32'd0);
        cycle("run3.after", 0, 0, 1, 0, 0);
        check("run3.single_pulse", 32'(expired), 32'd0);
`else
        cycle("run3.abort", 0, 0, 1, 1, 0);
`endif

        // Load 0: expiry on the first enabled edge.
        cycle("clr", 0, 0, 0, 0, 1);
        cycle("ld0", 1, 0, 0, 0, 0);
        cycle("ld0.exp", 0, 0, 1, 0, 0);
        check("ld0.exp_const", 32'(expired), 32'd1);
        if (busy) cycle("ld0.abort", 0, 0, 0, 1, 0);

        // Load 4 with two low-enable cycles: expiry 2 cycles late.
        cycle("ld4", 1, 4, 0, 0, 0);
        edges = 0; pulses = 0;
        while (edges < 16 && pulses == 0) begin
            cycle("run4", 0, 0, !(edges == 1 || edges == 2), 0, 0);
            edges++;
            if (expired) pulses++;
        end
        check("run4.cycles_to_expiry", 32'(edges), 32'd7);
        if (busy) cycle("run4.abort", 0, 0, 0, 1, 0);

        // Abort coincident with terminal count: no pulse, done stays 0.
        cycle("clr2", 0, 0, 0, 0, 1);
        cycle("ld1", 1, 1, 0, 0, 0);
        cycle("ld1.dec", 0, 0, 1, 0, 0);
        cycle("abort0", 0, 0, 1, 1, 0);
        check("abort0.exp_const",  32'(expired), 32'd0);
        check("abort0.done_const", 32'(done),    32'd0);
        check("abort0.busy_const", 32'(busy),    32'd0);

        // done_clr coincident with expiry: set wins.
        cycle("ld0b", 1, 0, 0, 0, 0);
        cycle("setwin", 0, 0, 1, 0, 1);
        check("setwin.done_const", 32'(done), 32'd1);
        if (busy) cycle("setwin.abort", 0, 0, 0, 1, 0);

`ifndef DOWN_TIMER_AUTO_RELOAD_EN
        // Held load_valid while running is not accepted until IDLE.
        cycle("ld2", 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("hold", 1, 7, 1, 0, 0);
        check("hold.expired_const", 32'(expired), 32'd1);
        check("hold.ready_const",   32'(load_ready), 32'd1);
        cycle("hold.take", 1, 7, 1, 0, 0);
        check("hold.loaded_const",  32'(count), 32'd7);
        cycle("hold.abort", 0, 0, 0, 1, 0);
`else
        // Reload: load 2, then 5 while running -> pulses at edges 3, 9, 15.
        cycle("rl2", 1, 2, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            cycle("rl", i == 1, 5, 1, 0, 0);
            if (expired) q.push_back(i);
        end
        check("rl.npulses", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            check("rl.p0", 32'(q[0]), 32'd3);
            check("rl.p1", 32'(q[1] - q[0]), 32'd6);
            check("rl.p2", 32'(q[2] - q[1]), 32'd6);
        end
        cycle("rl.abort", 0, 0, 1, 1, 0);
        check("rl.abort_busy", 32'(busy), 32'd0);
`endif

        // Randomized phase; producer holds load_valid/value until accepted.
        pend = 0; pval = 0;
        for (int i = 0; i < 1500; i++) begin
            bit acc;
            if (!pend && $urandom_range(3) == 0) begin
                pend = 1;
                pval = (($urandom_range(7) == 0) ? $urandom_range(15) : $urandom_range(5));
            end
            acc = pend && m_ready();
            cycle("rand", pend, pval, $urandom_range(9) < 7,
                  $urandom_range(19) == 0, $urandom_range(9) == 0);
            if (acc) pend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
